// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types for the two-port SRAM arbiter/controller.
// Package pocket: data-bus direction and controller FSM state encoding.
package pocket;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } sram_arb_state_e;

  localparam int SRAM_AW = 17;
  localparam int SRAM_DW = 16;

  // Active-low byte strobes {ub_n, lb_n}: writes honour be, reads use both bytes.
  function automatic logic [1:0] byte_strobe_n(input logic write, input logic [1:0] be);
    logic [1:0] strobe_n;
    if (write) begin
      strobe_n = ~be;
    end else begin
      strobe_n = 2'b00;
    end
    return strobe_n;
  endfunction

endpackage

// File: rtl/sram_if.sv
// Asynchronous SRAM pin bundle; the controller drives the ctrl modport.
interface sram_if;
  import pocket::*;

  logic [16:0] a;
  logic [15:0] data_out;
  logic [15:0] data_in;
  dir_e        dir;
  logic        oe_n;
  logic        we_n;
  logic        ub_n;
  logic        lb_n;

  modport ctrl (
    output a, data_out, dir, oe_n, we_n, ub_n, lb_n,
    input  data_in
  );

  modport mem (
    input  a, data_out, dir, oe_n, we_n, ub_n, lb_n,
    output data_in
  );
endinterface

// File: rtl/sram_arb_ctrl_arb.sv
// Two-requester arbiter. Macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin
// with a priority pointer; otherwise fixed priority, port 0 always wins.
module sram_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // ptr_q = 1 gives port 1 priority on a simultaneous request
  logic ptr_q;
  logic ptr_d;

  // Pick the winner from the pointer and compute the pointer after a grant
  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, reset favours port 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{clk, reset_n, advance};

  // Fixed priority: port 0 over port 1
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end
`endif
endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-port asynchronous SRAM controller: arbitrates, then runs
// SETUP / ACCESS(WAIT_CYCLES) / RECOVER(TURN_CYCLES). All outputs registered.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
module sram_arb_ctrl
  import pocket::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][16:0] req_addr,
  input  logic [1:0][15:0] req_wdata,
  input  logic [1:0][1:0]  req_be,
  output logic [1:0]       rsp_valid,
  output logic [15:0]      rsp_rdata,
  sram_if.ctrl             sram
);
  localparam int WCW = $clog2(WAIT_CYCLES + 1);
  localparam int TCW = $clog2(TURN_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES);
  localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYCLES);

  sram_arb_state_e state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic            port_q, port_d;
  logic            write_q, write_d;
  logic [1:0]      be_q, be_d;
  logic [1:0]      req_ready_q, req_ready_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic [16:0]     a_q, a_d;
  logic [15:0]     data_out_q, data_out_d;
  dir_e            dir_q, dir_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            ub_n_q, ub_n_d;
  logic            lb_n_q, lb_n_d;

  logic [1:0] grant_s;
  logic       advance_s;
  logic       sel_s;
  logic       accept_s;
  logic [1:0] strobe_n_s;

  // A grant is issued from IDLE only when no accept pulse is outstanding
  assign advance_s  = (state_q == IDLE) && (req_ready_q == 2'b00) && (req_valid != 2'b00);
  assign sel_s      = req_ready_q[1];
  assign accept_s   = (req_ready_q & req_valid) != 2'b00;
  assign strobe_n_s = byte_strobe_n(req_write[sel_s], req_be[sel_s]);

  sram_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // Next-state and next-output logic; outputs are set for the state being entered
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    port_d      = port_q;
    write_d     = write_q;
    be_d        = be_q;
    req_ready_d = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    a_d         = a_q;
    data_out_d  = data_out_q;
    dir_d       = dir_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    case (state_q)
      IDLE: begin
        if (req_ready_q != 2'b00) begin
          if (accept_s) begin
            port_d  = sel_s;
            write_d = req_write[sel_s];
            be_d    = req_be[sel_s];
            a_d     = req_addr[sel_s];
            ub_n_d  = strobe_n_s[1];
            lb_n_d  = strobe_n_s[0];
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            if (req_write[sel_s]) begin
              dir_d      = DIR_OUT;
              data_out_d = req_wdata[sel_s];
            end else begin
              dir_d      = DIR_IN;
              data_out_d = 16'h0000;
            end
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          req_ready_d = grant_s;
        end
      end
      SETUP: begin
        wcnt_d  = WAIT_LOAD;
        state_d = ACCESS;
        if (write_q) begin
          oe_n_d = 1'b1;
          we_n_d = (be_q == 2'b00);
        end else begin
          oe_n_d = 1'b0;
          we_n_d = 1'b1;
        end
      end
      ACCESS: begin
        if (wcnt_q == WCW'(1)) begin
          state_d = RECOVER;
          tcnt_d  = TURN_LOAD;
          if (!write_q) begin
            rsp_rdata_d = sram.data_in;
            rsp_valid_d = port_q ? 2'b10 : 2'b01;
          end else begin
            rsp_valid_d = 2'b00;
          end
          oe_n_d     = 1'b1;
          we_n_d     = 1'b1;
          ub_n_d     = 1'b1;
          lb_n_d     = 1'b1;
          dir_d      = DIR_IN;
          data_out_d = 16'h0000;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      RECOVER: begin
        if (tcnt_q == TCW'(1)) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q - TCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      port_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= 2'b00;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 16'h0000;
      a_q         <= 17'h00000;
      data_out_q  <= 16'h0000;
      dir_q       <= DIR_IN;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      port_q      <= port_d;
      write_q     <= write_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      a_q         <= a_d;
      data_out_q  <= data_out_d;
      dir_q       <= dir_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign sram.a        = a_q;
  assign sram.data_out = data_out_q;
  assign sram.dir      = dir_q;
  assign sram.oe_n     = oe_n_q;
  assign sram.we_n     = we_n_q;
  assign sram.ub_n     = ub_n_q;
  assign sram.lb_n     = lb_n_q;

endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: ACCESS-state length in clk cycles; legal range 1..15.
REQ-002 SHALL have parameter TURN_CYCLES, default 1: RECOVER-state length in clk cycles; legal range 1..7.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports req_valid[1:0], input, 2: request valid, one bit per requester i.
REQ-006 SHALL have port req_ready[1:0], output, 2: request accepted, one-cycle pulse per requester.
REQ-007 SHALL have port req_write[1:0], input, 2: 1 means write, 0 means read, per requester.
REQ-008 SHALL have port req_addr[1:0][16:0], input, 2x17: word address per requester.
REQ-009 SHALL have port req_wdata[1:0][15:0], input, 2x16: write data per requester.
REQ-010 SHALL have port req_be[1:0][1:0], input, 2x2: byte enables per requester; bit1 is the upper byte.
REQ-011 SHALL have port rsp_valid[1:0], output, 2: read data valid, one-cycle pulse per requester.
REQ-012 SHALL have port rsp_rdata[15:0], output, 16: read data shared by both requesters, qualified by rsp_valid.
REQ-013 SHALL have port sram, sram_if, -: drives a, data_out, dir, oe_n, we_n, ub_n, lb_n; samples data_in.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS, RECOVER; reset enters IDLE.
REQ-015 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly the granted port for one cycle, latch that port's cmd/addr/wdata/be, and go to SETUP.
REQ-016 A transfer is accepted when req_valid[i] and req_ready[i] are both high; a requester SHALL hold its inputs stable until then.
REQ-017 SETUP SHALL last 1 cycle: drive a, ub_n=~be and lb_n=~be (reads use both bytes), hold oe_n=we_n=1; for a write, also drive dir=DIR_OUT and data_out=wdata.
REQ-018 ACCESS SHALL last WAIT_CYCLES cycles, counted by a down-counter $clog2(WAIT_CYCLES+1) bits wide: for a read oe_n=0; for a write we_n=0 with dir/data_out held.
REQ-019 A read SHALL capture data_in on the last ACCESS cycle; rsp_rdata SHALL update and rsp_valid[granted] pulse 1 cycle on the first RECOVER cycle.
REQ-020 RECOVER SHALL last TURN_CYCLES cycles with oe_n=we_n=ub_n=lb_n=1 and dir=DIR_IN, then go to IDLE.
REQ-021 Read latency from acceptance in cycle T SHALL be rsp_valid in cycle T+2+WAIT_CYCLES; the service interval between accepts SHALL be 3+WAIT_CYCLES+TURN_CYCLES cycles.
REQ-022 A write with be=2'b00 SHALL run the full sequence with we_n held high throughout.
REQ-023 sram.a and rsp_rdata SHALL hold their last value outside SETUP/ACCESS; data_out SHALL be 0 whenever dir=DIR_IN.
REQ-024 dir=DIR_OUT and oe_n=0 SHALL never occur in the same cycle.
REQ-025 No new grant SHALL occur outside IDLE; req_valid changes there SHALL be ignored.

Reset
REQ-026 With reset_n low at a clk edge, the block SHALL abort any access and go to IDLE.
REQ-027 Reset values SHALL be: req_ready=0, rsp_valid=0, rsp_rdata=0, a=0, data_out=0, dir=DIR_IN, oe_n=we_n=ub_n=lb_n=1, arbitration pointer favouring port 0.
REQ-028 A read aborted by reset SHALL produce no rsp_valid.

Configuration
REQ-029 With SRAM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: after a grant to port i, port ~i has priority on the next simultaneous request.
REQ-030 Without SRAM_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with port 0 always winning, and no pointer register SHALL exist.

Structure
REQ-031 Package pocket SHALL hold the typedef sram_arb_state_e (IDLE/SETUP/ACCESS/RECOVER), reusing the existing pocket::dir_e.
REQ-032 Arbitration SHALL be a sub-module sram_rr_arb2: inputs req[1:0], advance; output one-hot grant[1:0]; contains the round-robin pointer under the macro.

Verification
REQ-033 Port0 write addr=0x1ABCD, wdata=0x5AA5, be=11 -> one req_ready[0]; we_n low 2 cycles; a=0x1ABCD; dir=DIR_OUT in SETUP+ACCESS only.
REQ-034 Port1 read of addr=0x1ABCD after REQ-033, model returns 0x5AA5 -> rsp_valid[1] at T+4, rsp_rdata=0x5AA5, oe_n low 2 cycles.
REQ-035 Both ports valid continuously, macro defined -> grants alternate 0,1,0,1 every 6 cycles; macro undefined -> port 0 granted every time.
REQ-036 Write be=10 then be=00 -> first gives ub_n=0, lb_n=1; second gives we_n never low and the FSM still returns to IDLE.
REQ-037 reset_n low during ACCESS of a read -> next cycle oe_n=1, dir=DIR_IN, state IDLE, no rsp_valid.
REQ-038 WAIT_CYCLES=5, TURN_CYCLES=3 -> read latency 7 cycles, accept interval 11 cycles; assertion that dir=DIR_OUT and oe_n=0 never coincide across all tests.
